// File: rtl/flash_responder.sv
// Device-side model of an 8-bit parallel NOR flash: 256 x 8 array, command FSM,
// status register and busy indication, with all pins synchronized into clk_f.
module flash_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int READ_LAT     = 2,
    parameter int PROG_CYCLES  = 16,
    parameter int ERASE_CYCLES = 300
) (
    input  logic       clk_f,
    input  logic       rst,
    input  logic       NF_CE,
    input  logic       NF_OE,
    input  logic       NF_WE,
    input  logic       NF_RP,
    input  logic       NF_BYTE,
    input  logic [7:0] NF_A,
    input  logic [7:0] NF_D_IN,
    output logic [7:0] NF_D_OUT,
    output logic       NF_D_OE,
    output logic       NF_STS
);
    localparam logic [2:0] READ_ARRAY  = 3'd0;
    localparam logic [2:0] READ_STATUS = 3'd1;
    localparam logic [2:0] PROG_SETUP  = 3'd2;
    localparam logic [2:0] ERASE_SETUP = 3'd3;
    localparam logic [2:0] PROG_BUSY   = 3'd4;
    localparam logic [2:0] ERASE_BUSY  = 3'd5;

    localparam int          SW        = 20;
    // Pins idle high (CE/OE/WE/RP), address and data zero.
    localparam logic [SW-1:0] SYNC_IDLE = 20'hF0000;

    // Only x8 mode exists here, so NF_BYTE carries no information.
    logic unused_byte;
    assign unused_byte = NF_BYTE;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];

    assign sync_d[0] = {NF_RP, NF_WE, NF_OE, NF_CE, NF_A, NF_D_IN};
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_f) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
        end else begin
            sync_q <= sync_d;
        end
    end

    logic       ce_s, oe_s, we_s, rp_s;
    logic [7:0] a_s, d_s;
    assign {rp_s, we_s, oe_s, ce_s, a_s, d_s} = sync_q[SYNC_STAGES-1];

    logic [7:0] mem [0:255] = '{default: 8'hFF};

    logic [2:0]  state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  idx_q, idx_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        d_oe_q, d_oe_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        we_prev_q, we_prev_d;

    logic       write_stb;
    logic [7:0] mem_rd;
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;

    assign write_stb = !ce_s && !we_prev_q && we_s;
    assign mem_rd    = mem[a_s];

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_waddr = a_s;
        mem_wdata = d_s;
        we_prev_d = we_s;

        case (state_q)
            READ_ARRAY, READ_STATUS: begin
                if (write_stb) begin
                    case (d_s)
                        8'hFF:        state_d = READ_ARRAY;
                        8'h70:        state_d = READ_STATUS;
                        8'h50:        sr_d    = sr_q & 8'hCF;
                        8'h40, 8'h10: state_d = PROG_SETUP;
                        8'h20:        state_d = ERASE_SETUP;
                        default:      state_d = state_q;
                    endcase
                end
            end
            PROG_SETUP: begin
                if (write_stb) begin
                    mem_we    = 1'b1;
                    mem_wdata = mem_rd & d_s;
                    if ((d_s & ~mem_rd) != 8'h00) sr_d[4] = 1'b1;
                    sr_d[7] = 1'b0;
                    state_d = PROG_BUSY;
                    cnt_d   = 16'(PROG_CYCLES);
                end
            end
            ERASE_SETUP: begin
                if (write_stb) begin
                    if (d_s == 8'hD0) begin
                        sr_d[7] = 1'b0;
                        state_d = ERASE_BUSY;
                        cnt_d   = 16'(ERASE_CYCLES);
                        idx_d   = 9'd0;
                    end else begin
                        sr_d    = sr_q | 8'h30;
                        state_d = READ_STATUS;
                    end
                end
            end
            PROG_BUSY, ERASE_BUSY: begin
                cnt_d = cnt_q - 16'd1;
                // The erase sweep runs alongside the busy countdown, one byte per cycle.
                if (state_q == ERASE_BUSY && !idx_q[8]) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q[7:0];
                    mem_wdata = 8'hFF;
                    idx_d     = idx_q + 9'd1;
                end
                if (cnt_q == 16'd1) begin
                    sr_d[7] = 1'b1;
                    state_d = READ_STATUS;
                end
            end
            default: state_d = READ_ARRAY;
        endcase
        sr_d = sr_d & 8'hB0;

        if (!rst || !rp_s) mem_we = 1'b0;

        rd_cnt_d = 4'd0;
        if (!ce_s && !oe_s)
            rd_cnt_d = (rd_cnt_q == 4'(READ_LAT)) ? rd_cnt_q : rd_cnt_q + 4'd1;
        // A pending write (WE low) keeps the data bus released.
        d_oe_d  = (rd_cnt_d == 4'(READ_LAT)) && we_s;
        d_out_d = (state_q == READ_ARRAY) ? mem_rd : sr_q;
    end

    always_ff @(posedge clk_f) begin
        if (!rst || !rp_s) begin
            state_q   <= READ_ARRAY;
            sr_q      <= 8'h80;
            cnt_q     <= 16'd0;
            idx_q     <= 9'd0;
            rd_cnt_q  <= 4'd0;
            d_oe_q    <= 1'b0;
            d_out_q   <= 8'h00;
            we_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rd_cnt_q  <= rd_cnt_d;
            d_oe_q    <= d_oe_d;
            d_out_q   <= d_out_d;
            we_prev_q <= we_prev_d;
        end
    end

    always_ff @(posedge clk_f) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign NF_D_OUT = d_out_q;
    assign NF_D_OE  = d_oe_q;
    assign NF_STS   = !(state_q == PROG_BUSY || state_q == ERASE_BUSY);
endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: read latency, program, erase, bad confirm,
// and an erase aborted by NF_RP.
module tb_flash_responder;
    logic       clk;
    logic       rst;
    logic       nf_ce, nf_oe, nf_we, nf_rp, nf_byte;
    logic [7:0] nf_a, nf_d_in;
    logic [7:0] nf_d_out;
    logic       nf_d_oe, nf_sts;

    int checks   = 0;
    int failures = 0;
    int low_total = 0;

    flash_responder #(
        .SYNC_STAGES (2),
        .READ_LAT    (2),
        .PROG_CYCLES (16),
        .ERASE_CYCLES(300)
    ) dut (
        .clk_f   (clk),
        .rst     (rst),
        .NF_CE   (nf_ce),
        .NF_OE   (nf_oe),
        .NF_WE   (nf_we),
        .NF_RP   (nf_rp),
        .NF_BYTE (nf_byte),
        .NF_A    (nf_a),
        .NF_D_IN (nf_d_in),
        .NF_D_OUT(nf_d_out),
        .NF_D_OE (nf_d_oe),
        .NF_STS  (nf_sts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of cycles with NF_STS low.
    always @(negedge clk) if (nf_sts === 1'b0) low_total++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic flash_write(input logic [7:0] a, input logic [7:0] d);
        nf_a = a; nf_d_in = d; nf_ce = 1'b0;
        tick(3);
        nf_we = 1'b0;
        tick(4);
        nf_we = 1'b1;
        tick(4);
        nf_ce = 1'b1;
        tick(3);
        $display("write a=0x%02h d=0x%02h", a, d);
    endtask

    task automatic flash_read(input logic [7:0] a, output logic [7:0] v);
        nf_a = a; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(6);
        v = nf_d_out;
        nf_ce = 1'b1; nf_oe = 1'b1;
        tick(3);
    endtask

    task automatic wait_ready(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (nf_sts !== 1'b1 && i < max_cycles) begin
            tick(1);
            i++;
        end
        check(tag, nf_sts, 1);
    endtask

    task automatic program_byte(input logic [7:0] a, input logic [7:0] d);
        flash_write(8'h00, 8'h40);
        flash_write(a, d);
        wait_ready("prog_ready", 100);
    endtask

    initial begin
        logic [7:0] v;
        int base, bad;

        rst = 1'b0; nf_ce = 1'b1; nf_oe = 1'b1; nf_we = 1'b1; nf_rp = 1'b1;
        nf_byte = 1'b0; nf_a = 8'h00; nf_d_in = 8'h00;
        tick(5);
        check("rst_sts", nf_sts, 1);
        check("rst_doe", nf_d_oe, 0);
        check("rst_dout", nf_d_out, 8'h00);
        rst = 1'b1;
        tick(2);

        // Read latency: 2 sync stages + READ_LAT
        nf_a = 8'h10; nf_ce = 1'b0; nf_oe = 1'b0;
        tick(3);
        check("rd_lat_early", nf_d_oe, 0);
        tick(1);
        check("rd_lat_oe", nf_d_oe, 1);
        check("rd_init_ff", nf_d_out, 8'hFF);
        check("rd_sts", nf_sts, 1);
        nf_oe = 1'b1;
        tick(2);
        check("oe_drop_hold", nf_d_oe, 1);
        tick(1);
        check("oe_drop", nf_d_oe, 0);
        nf_ce = 1'b1;
        tick(3);
        $display("read latency sequence done");

        // Program 0x5A into 0x10
        flash_write(8'h00, 8'h40);
        base = low_total;
        flash_write(8'h10, 8'h5A);
        flash_read(8'h10, v);
        check("prog_busy_sr", v, 8'h00);
        check("prog_busy_sts", nf_sts, 0);
        wait_ready("prog1_ready", 100);
        check("prog_busy_len", low_total - base, 16);
        flash_read(8'h10, v);
        check("prog_done_sr", v, 8'h80);
        flash_write(8'h00, 8'hFF);
        flash_read(8'h10, v);
        check("prog_data", v, 8'h5A);
        $display("read a=0x10 d=0x%02h", v);

        // Program 0xA5 over 0x5A: AND gives 0x00, SR4 flags the 0->1 attempt
        program_byte(8'h10, 8'hA5);
        flash_read(8'h10, v);
        check("prog_sr4", v, 8'h90);
        flash_write(8'h00, 8'h50);
        flash_read(8'h10, v);
        check("clr_sr", v, 8'h80);
        flash_write(8'h00, 8'hFF);
        flash_read(8'h10, v);
        check("prog_and", v, 8'h00);

        // Highest address, then full erase
        program_byte(8'hFF, 8'h34);
        flash_write(8'h00, 8'hFF);
        flash_read(8'hFF, v);
        check("prog_top", v, 8'h34);
        flash_write(8'h00, 8'h20);
        base = low_total;
        flash_write(8'h00, 8'hD0);
        wait_ready("erase_ready", 1000);
        check("erase_busy_len", low_total - base, 300);
        flash_read(8'h00, v);
        check("erase_sr", v, 8'h80);
        flash_write(8'h00, 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            flash_read(8'(i), v);
            if (v !== 8'hFF) bad++;
        end
        check("erase_all_ff", bad, 0);
        $display("erase sweep checked, nonblank=%0d", bad);

        // Erase with a bad confirm byte
        flash_write(8'h00, 8'h20);
        base = low_total;
        flash_write(8'h00, 8'h33);
        check("bad_conf_nobusy", low_total - base, 0);
        flash_read(8'h10, v);
        check("bad_conf_sr", v, 8'hB0);
        flash_write(8'h00, 8'h50);
        flash_write(8'h00, 8'hFF);
        flash_read(8'h10, v);
        check("bad_conf_array", v, 8'hFF);

        // Erase aborted by NF_RP after 100 busy cycles
        program_byte(8'h10, 8'h00);
        program_byte(8'h80, 8'h12);
        program_byte(8'hFF, 8'h34);
        flash_write(8'h00, 8'h20);
        base = low_total;
        flash_write(8'h00, 8'hD0);
        for (int i = 0; i < 400 && (low_total - base) < 100; i++) tick(1);
        check("abort_reach", low_total - base, 100);
        check("abort_busy", nf_sts, 0);
        nf_rp = 1'b0;
        tick(3);
        check("abort_sts", nf_sts, 1);
        check("abort_doe", nf_d_oe, 0);
        nf_rp = 1'b1;
        tick(4);
        flash_read(8'h00, v);
        check("abort_a00", v, 8'hFF);
        flash_read(8'h10, v);
        check("abort_a10", v, 8'hFF);
        flash_read(8'h60, v);
        check("abort_a60", v, 8'hFF);
        flash_read(8'h80, v);
        check("abort_a80", v, 8'h12);
        flash_read(8'hFF, v);
        check("abort_aff", v, 8'h34);
        flash_write(8'h00, 8'h70);
        flash_read(8'h00, v);
        check("abort_sr", v, 8'h80);
        $display("abort sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
